// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : lsu_pkg
// Shared definitions for the load/store unit: RV32I funct3 size/sign codes,
// the controller state encoding and the default data-memory depth.
// Revision: 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // RV32I load/store size and sign codes.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Words in the attached data memory unless overridden.
  localparam int unsigned LSU_DEPTH_DEFAULT = 21;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_lane_align
// Combinational byte/halfword lane handling for the load/store unit.
//   word_i    : word captured from memory
//   addr_lo_i : byte offset within the word
//   funct3_i  : RV32I size/sign code
//   wdata_i   : right-aligned store data
//   load_o    : extracted and sign/zero-extended load result
//   merge_o   : word_i with the store lane(s) replaced by wdata_i
// Revision: 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  w_bit_off;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_bit_off = {addr_lo_i, 3'b000};
  assign w_byte    = word_i[w_bit_off +: 8];
  assign w_half    = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    load_o = word_i;
    case (funct3_i)
      F3_B:    load_o = {{24{w_byte[7]}}, w_byte};
      F3_H:    load_o = {{16{w_half[15]}}, w_half};
      F3_BU:   load_o = {24'h0, w_byte};
      F3_HU:   load_o = {16'h0, w_half};
      default: load_o = word_i;
    endcase
  end

  always_comb begin
    merge_o = word_i;
    case (funct3_i)
      F3_B: merge_o[w_bit_off +: 8] = wdata_i[7:0];
      F3_H: begin
        if (addr_lo_i[1]) merge_o[31:16] = wdata_i[15:0];
        else              merge_o[15:0]  = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : load_store_unit
// Initiator side of a word-addressed data memory without byte enables.
// Executes RV32I loads/stores one at a time; sub-word stores are done as
// read-modify-write. Memory pins are decoded from registered state only.
//   CLK, RST          : clock, synchronous active-high reset
//   req_*             : request handshake from execute (ready only in IDLE)
//   resp_*            : single-cycle response pulse with data/error
//   MEM_*             : data memory RW/EN/word index/write data/read data
// Revision: 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = LSU_DEPTH_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        MEM_RW,
  output logic        MEM_EN,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_DIN,
  input  logic [31:0] MEM_DOUT
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  lsu_state_e  state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  f3_q,    f3_d;
  logic [31:0] addr_q,  addr_d;
  // Holds store data on acceptance; overwritten with the merged word at CAP.
  logic [31:0] wbuf_q,  wbuf_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rerr_q,  rerr_d;

  logic        w_f3_ok;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_req_err;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  // Request legality, evaluated on the raw request in IDLE.
  always_comb begin
    w_f3_ok = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: w_f3_ok = 1'b1;
      F3_BU, F3_HU:     w_f3_ok = ~req_store;
      default:          w_f3_ok = 1'b0;
    endcase
  end

  assign w_misaligned   = ((req_funct3 == F3_H) && req_addr[0]) ||
                          ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
  assign w_out_of_range = ({2'b00, req_addr[31:2]} >= DEPTH_W);
  assign w_req_err      = ~w_f3_ok | w_misaligned | w_out_of_range;

  lsu_lane_align u_align (
    .word_i    (MEM_DOUT),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (f3_q),
    .wdata_i   (wbuf_q),
    .load_o    (w_load),
    .merge_o   (w_merge)
  );

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wbuf_d  = req_wdata;
          if (w_req_err) begin
            rdata_d = 32'h0;
            rerr_d  = 1'b1;
            state_d = ST_RESP;
          end else if (req_store && (req_funct3 == F3_W)) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP: begin
        // MEM_DOUT is valid only during CAP.
        if (store_q) begin
          wbuf_d  = w_merge;
          state_d = ST_WR;
        end else begin
          rdata_d = w_load;
          rerr_d  = 1'b0;
          state_d = ST_RESP;
        end
      end
      ST_WR: begin
        rdata_d = wbuf_q;
        rerr_d  = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      store_q <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wbuf_q  <= 32'h0;
      rdata_q <= 32'h0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE) && !RST;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_data  = rdata_q;
  assign resp_err   = rerr_q;

  assign MEM_EN   = (state_q == ST_RD) || (state_q == ST_WR);
  assign MEM_RW   = (state_q == ST_WR);
  assign MEM_ADDR = {2'b00, addr_q[31:2]};
  assign MEM_DIN  = (state_q == ST_WR) ? wbuf_q : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_load_store_unit
// Self-checking bench for load_store_unit with a behavioural data memory.
// Requests push their expected response into a scoreboard queue; a monitor
// pops and compares whenever resp_valid is seen.
// Revision: 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        MEM_RW;
  logic        MEM_EN;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_DIN;
  logic [31:0] MEM_DOUT = 32'h0;

  always #5 CLK = ~CLK;

  load_store_unit #(.DEPTH(21)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .MEM_RW     (MEM_RW),
    .MEM_EN     (MEM_EN),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_DIN    (MEM_DIN),
    .MEM_DOUT   (MEM_DOUT)
  );

  // Data memory model, with a backdoor preload port.
  logic [31:0] mem [0:31];
  logic        pl_en   = 1'b0;
  logic [4:0]  pl_idx  = 5'd0;
  logic [31:0] pl_data = 32'h0;

  always @(posedge CLK) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (MEM_EN) begin
      if (MEM_RW) mem[MEM_ADDR[4:0]] <= MEM_DIN;
      MEM_DOUT <= mem[MEM_ADDR[4:0]];
    end else begin
      MEM_DOUT <= 32'h0;
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
    string       nm;
  } exp_t;

  exp_t sb[$];

  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_din = 32'h0;
  logic [31:0] last_rd_addr = 32'h0;

  // Monitor: memory-pin activity and response scoreboard.
  always @(negedge CLK) begin
    if (MEM_EN === 1'b1 && MEM_RW === 1'b0) begin
      rd_cnt++;
      last_rd_addr = MEM_ADDR;
    end
    if (MEM_EN === 1'b1 && MEM_RW === 1'b1) begin
      wr_cnt++;
      last_din = MEM_DIN;
    end
    if (MEM_EN === 1'b0) check("quiet_mem_pins", {31'h0, MEM_RW, MEM_DIN}, 64'h0);
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 64'(resp_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.nm, "_data"}, 64'(resp_data), 64'(e.data));
        check({e.nm, "_err"},  64'(resp_err),  64'(e.err));
        check({e.nm, "_lat"},  64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge CLK);
    pl_en   = 1'b1;
    pl_idx  = 5'(idx);
    pl_data = d;
    @(posedge CLK);
    #1 pl_en = 1'b0;
  endtask

  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] ed, input bit ee,
                       input int lat, input int exp_rd, input int exp_wr,
                       input string nm);
    exp_t e;
    int rd0, wr0;
    @(negedge CLK);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    check({nm, "_ready"}, 64'(req_ready), 64'h1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    e.data = ed; e.err = ee; e.lat = lat; e.acc = cyc; e.nm = nm;
    sb.push_back(e);
    @(posedge CLK);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge CLK);
    if (sb.size() != 0) begin
      check({nm, "_timeout"}, 64'(sb.size()), 64'h0);
      sb.delete();
    end
    @(negedge CLK);
    check({nm, "_rd_cycles"}, 64'(rd_cnt - rd0), 64'(exp_rd));
    check({nm, "_wr_cycles"}, 64'(wr_cnt - wr0), 64'(exp_wr));
  endtask

  initial begin
    int wr_before;
    RST = 1'b1; req_valid = 1'b0; req_store = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;

    // Reset for two cycles.
    @(negedge CLK);
    check("rst_ready_low", 64'(req_ready), 64'h0);
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    @(negedge CLK);
    check("rst_ready_low2", 64'(req_ready), 64'h0);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_ready", 64'(req_ready), 64'h1);
    check("rst_outs", {resp_valid, resp_err, MEM_EN, MEM_RW, 28'h0},  64'h0);
    check("rst_resp_data", 64'(resp_data), 64'h0);
    check("rst_mem_addr", 64'(MEM_ADDR), 64'h0);
    check("rst_mem_din", 64'(MEM_DIN), 64'h0);

    // Word load.
    preload(2, 32'hDEADBEEF);
    issue(0, 3'b010, 32'h8, 0, 32'hDEADBEEF, 0, 3, 1, 0, "lw_8");
    check("lw_8_rd_addr", 64'(last_rd_addr), 64'h2);

    // Byte/halfword loads with sign and zero extension.
    preload(2, 32'h80FF7F01);
    issue(0, 3'b000, 32'hB, 0, 32'hFFFFFF80, 0, 3, 1, 0, "lb_b");
    issue(0, 3'b100, 32'hB, 0, 32'h00000080, 0, 3, 1, 0, "lbu_b");
    issue(0, 3'b001, 32'hA, 0, 32'hFFFF80FF, 0, 3, 1, 0, "lh_a");
    issue(0, 3'b101, 32'h8, 0, 32'h00007F01, 0, 3, 1, 0, "lhu_8");
    issue(0, 3'b000, 32'h9, 0, 32'h0000007F, 0, 3, 1, 0, "lb_9");
    issue(0, 3'b101, 32'hA, 0, 32'h000080FF, 0, 3, 1, 0, "lhu_a");

    // Sub-word store by read-modify-write.
    preload(2, 32'h11223344);
    issue(1, 3'b000, 32'h9, 32'h000000AA, 32'h1122AA44, 0, 4, 1, 1, "sb_9");
    check("sb_9_din", 64'(last_din), 64'h1122AA44);
    check("sb_9_mem", 64'(mem[2]), 64'h1122AA44);
    issue(0, 3'b010, 32'h8, 0, 32'h1122AA44, 0, 3, 1, 0, "lw_after_sb");

    // Word store, then sub-word stores into the same word.
    issue(1, 3'b010, 32'h0, 32'h12345678, 32'h12345678, 0, 2, 0, 1, "sw_0");
    check("sw_0_mem", 64'(mem[0]), 64'h12345678);
    issue(1, 3'b001, 32'h2, 32'h0000BEEF, 32'hBEEF5678, 0, 4, 1, 1, "sh_2");
    issue(1, 3'b000, 32'h3, 32'hFFFFFF11, 32'h11EF5678, 0, 4, 1, 1, "sb_3");
    issue(0, 3'b010, 32'h0, 0, 32'h11EF5678, 0, 3, 1, 0, "lw_0");

    // Last valid word index.
    preload(20, 32'hCAFEF00D);
    issue(0, 3'b010, 32'h50, 0, 32'hCAFEF00D, 0, 3, 1, 0, "lw_top");
    issue(0, 3'b101, 32'h52, 0, 32'h0000CAFE, 0, 3, 1, 0, "lhu_top");

    // Errors: one cycle, zero data, no memory access.
    issue(0, 3'b010, 32'h6,        0, 32'h0, 1, 1, 0, 0, "err_lw_mis");
    issue(1, 3'b001, 32'h3,        32'h5555, 32'h0, 1, 1, 0, 0, "err_sh_mis");
    issue(0, 3'b001, 32'h1,        0, 32'h0, 1, 1, 0, 0, "err_lh_mis");
    issue(0, 3'b010, 32'h54,       0, 32'h0, 1, 1, 0, 0, "err_range");
    issue(0, 3'b010, 32'hFFFFFFFC, 0, 32'h0, 1, 1, 0, 0, "err_range_hi");
    issue(0, 3'b011, 32'h0,        0, 32'h0, 1, 1, 0, 0, "err_f3_011");
    issue(1, 3'b100, 32'h0,        32'h1, 32'h0, 1, 1, 0, 0, "err_sbu");
    issue(0, 3'b010, 32'h8, 0, 32'h1122AA44, 0, 3, 1, 0, "lw_after_err");

    // Reset during the CAP cycle of a byte store.
    preload(2, 32'h55667788);
    @(negedge CLK);
    wr_before = wr_cnt;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h9; req_wdata = 32'h000000AA;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(negedge CLK);
    check("abort_rd_en", {63'h0, MEM_EN}, 64'h1);
    @(negedge CLK);
    check("abort_cap_en", {63'h0, MEM_EN}, 64'h0);
    RST = 1'b1;
    @(negedge CLK);
    check("abort_outs", {resp_valid, resp_err, MEM_EN, MEM_RW, 28'h0}, 64'h0);
    check("abort_resp_data", 64'(resp_data), 64'h0);
    check("abort_mem_addr", 64'(MEM_ADDR), 64'h0);
    check("abort_mem_din", 64'(MEM_DIN), 64'h0);
    check("abort_ready_in_rst", 64'(req_ready), 64'h0);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    check("abort_no_write", 64'(wr_cnt - wr_before), 64'h0);
    check("abort_mem", 64'(mem[2]), 64'h55667788);
    issue(0, 3'b010, 32'h8, 0, 32'h55667788, 0, 3, 1, 0, "lw_after_abort");

    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
